arp_rx_parser: RTL and testbench

- Receive-side ARP front end, directly upstream of the transmit block-state FSM.
- Consumes the MAC receive byte stream, walks the 42-byte Ethernet/ARP header with its own byte counter, and checks each field.
- Captures the requester's hardware and protocol addresses.
- On a valid ARP request for our IP, raises the level `start` that launches the reply FSM, and holds it until that FSM reaches END.

---
 rtl/arp_rx_parser_pkg.sv | 57 +++++
 rtl/arp_rx_field_chk.sv | 53 +++++
 rtl/arp_rx_parser.sv | 177 +++++++++++++++++
 tb/tb_arp_rx_parser.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arp_rx_parser_pkg.sv
// Shared constants, parser state codes and small helpers for the ARP
// receive front end.
package arp_rx_parser_pkg;

  // Fixed ARP-over-Ethernet header field values
  localparam logic [15:0] ARP_ETHERTYPE = 16'h0806;
  localparam logic [15:0] HTYPE_ETH     = 16'h0001;
  localparam logic [15:0] PTYPE_IPV4    = 16'h0800;
  localparam logic [7:0]  HLEN          = 8'd6;
  localparam logic [7:0]  PLEN          = 8'd4;
  localparam logic [15:0] OPER_REQ      = 16'h0001;

  // Byte offsets inside the 42-byte Ethernet/ARP header
  localparam logic [5:0] DMAC_LAST = 6'd5;
  localparam logic [5:0] SHA_OFS   = 6'd22;
  localparam logic [5:0] SPA_OFS   = 6'd28;
  localparam logic [5:0] TPA_OFS   = 6'd38;
  localparam logic [5:0] HDR_LAST  = 6'd41;

  // Parser state codes
  typedef enum logic [1:0] {
    P_IDLE  = 2'd0,
    P_HDR   = 2'd1,
    P_TAIL  = 2'd2,
    P_CHECK = 2'd3
  } parse_state_t;

  // Byte i of a MAC address, i = 0 being the first byte on the wire
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] i);
    case (i)
      3'd0:    mac_byte = mac[47:40];
      3'd1:    mac_byte = mac[39:32];
      3'd2:    mac_byte = mac[31:24];
      3'd3:    mac_byte = mac[23:16];
      3'd4:    mac_byte = mac[15:8];
      3'd5:    mac_byte = mac[7:0];
      default: mac_byte = 8'h00;
    endcase
  endfunction

  // Byte i of an IPv4 address, i = 0 being the first byte on the wire
  function automatic logic [7:0] ip_byte(input logic [31:0] ip, input logic [1:0] i);
    case (i)
      2'd0:    ip_byte = ip[31:24];
      2'd1:    ip_byte = ip[23:16];
      2'd2:    ip_byte = ip[15:8];
      2'd3:    ip_byte = ip[7:0];
      default: ip_byte = 8'h00;
    endcase
  endfunction

  // Increment that sticks at the top value
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? 8'hFF : (v + 8'd1);
  endfunction

endpackage

// File: rtl/arp_rx_field_chk.sv
// Combinational per-byte field checker: given the header byte index and the
// byte value, reports whether the byte is acceptable, the two destination-MAC
// match candidates, and which shadow register (SHA/SPA) should capture it.
module arp_rx_field_chk
  import arp_rx_parser_pkg::*;
#(
  parameter logic [47:0] MY_MAC = 48'h000A35010203,
  parameter logic [31:0] MY_IP  = 32'hC0A80164
) (
  input  logic [5:0] idx,
  input  logic [7:0] data,
  output logic       byte_ok,
  output logic       is_dmac,
  output logic       bcast_ok,
  output logic       mine_ok,
  output logic       sha_en,
  output logic       spa_en
);

  logic [1:0] tpa_rel_s;

  // Decode the byte position and compare against the expected field value
  always_comb begin
    byte_ok   = 1'b1;
    is_dmac   = 1'b0;
    bcast_ok  = 1'b0;
    mine_ok   = 1'b0;
    sha_en    = (idx >= SHA_OFS) && (idx < SPA_OFS);
    spa_en    = (idx >= SPA_OFS) && (idx < (SPA_OFS + 6'd4));
    tpa_rel_s = idx[1:0] - TPA_OFS[1:0];
    case (idx)
      6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5: begin
        // Destination MAC is judged as a whole group by the parser
        is_dmac  = 1'b1;
        bcast_ok = (data == 8'hFF);
        mine_ok  = (data == mac_byte(MY_MAC, idx[2:0]));
      end
      6'd12:   byte_ok = (data == ARP_ETHERTYPE[15:8]);
      6'd13:   byte_ok = (data == ARP_ETHERTYPE[7:0]);
      6'd14:   byte_ok = (data == HTYPE_ETH[15:8]);
      6'd15:   byte_ok = (data == HTYPE_ETH[7:0]);
      6'd16:   byte_ok = (data == PTYPE_IPV4[15:8]);
      6'd17:   byte_ok = (data == PTYPE_IPV4[7:0]);
      6'd18:   byte_ok = (data == HLEN);
      6'd19:   byte_ok = (data == PLEN);
      6'd20:   byte_ok = (data == OPER_REQ[15:8]);
      6'd21:   byte_ok = (data == OPER_REQ[7:0]);
      6'd38, 6'd39, 6'd40, 6'd41: byte_ok = (data == ip_byte(MY_IP, tpa_rel_s));
      default: byte_ok = 1'b1;
    endcase
  end

endmodule

// File: rtl/arp_rx_parser.sv
// ARP receive parser: walks the Ethernet/ARP header of each received frame,
// captures the requester's addresses and raises a level start towards the
// reply FSM for a valid request to our IP. Rejected frames are counted.
module arp_rx_parser
  import arp_rx_parser_pkg::*;
#(
  parameter logic [47:0] MY_MAC = 48'h000A35010203,
  parameter logic [31:0] MY_IP  = 32'hC0A80164
) (
  input  logic        clk,
  input  logic        areset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_sof,
  input  logic        rx_eof,
  input  logic        tx_done,
  output logic        reply_start,
  output logic [47:0] req_mac,
  output logic [31:0] req_ip,
  output logic [7:0]  drop_cnt
);

  parse_state_t state_r, state_nx;
  logic [5:0]   idx_r, idx_nx, chk_idx_s;
  logic         match_r, match_nx;
  logic         bcast_r, bcast_nx;
  logic         mine_r, mine_nx;
  logic [47:0]  sha_r, sha_nx;
  logic [31:0]  spa_r, spa_nx;
  logic         start_r, start_nx;
  logic [47:0]  mac_r, mac_nx;
  logic [31:0]  ip_r, ip_nx;
  logic [7:0]   drop_r, drop_nx;

  logic hdr_byte_s;
  logic byte_ok_s, is_dmac_s, bcast_ok_s, mine_ok_s, sha_en_s, spa_en_s;
  logic match_base_s, bcast_base_s, mine_base_s, dmac_fail_s;

  // A start-of-frame byte is always header byte 0, whatever state we are in
  assign chk_idx_s  = rx_sof ? 6'd0 : idx_r;
  assign hdr_byte_s = rx_valid & (rx_sof | (state_r == P_HDR));

  arp_rx_field_chk #(
    .MY_MAC (MY_MAC),
    .MY_IP  (MY_IP)
  ) u_field_chk (
    .idx      (chk_idx_s),
    .data     (rx_data),
    .byte_ok  (byte_ok_s),
    .is_dmac  (is_dmac_s),
    .bcast_ok (bcast_ok_s),
    .mine_ok  (mine_ok_s),
    .sha_en   (sha_en_s),
    .spa_en   (spa_en_s)
  );

  // Next-state logic: header walk, field accumulation and accept/reject decision
  always_comb begin
    state_nx     = state_r;
    idx_nx       = idx_r;
    match_nx     = match_r;
    bcast_nx     = bcast_r;
    mine_nx      = mine_r;
    sha_nx       = sha_r;
    spa_nx       = spa_r;
    mac_nx       = mac_r;
    ip_nx        = ip_r;
    drop_nx      = drop_r;
    dmac_fail_s  = 1'b0;
    match_base_s = rx_sof ? 1'b1 : match_r;
    bcast_base_s = rx_sof ? 1'b1 : bcast_r;
    mine_base_s  = rx_sof ? 1'b1 : mine_r;

    // Reply FSM has reached END: let it go back to IDLE
    if (start_r && tx_done) begin
      start_nx = 1'b0;
    end else begin
      start_nx = start_r;
    end

    if (hdr_byte_s) begin
      bcast_nx = bcast_base_s & (bcast_ok_s | ~is_dmac_s);
      mine_nx  = mine_base_s & (mine_ok_s | ~is_dmac_s);
      if (chk_idx_s == DMAC_LAST) begin
        dmac_fail_s = ~(bcast_nx | mine_nx);
      end else begin
        dmac_fail_s = 1'b0;
      end
      match_nx = match_base_s & byte_ok_s & ~dmac_fail_s;
      if (sha_en_s) begin
        sha_nx = {sha_r[39:0], rx_data};
      end else begin
        sha_nx = sha_r;
      end
      if (spa_en_s) begin
        spa_nx = {spa_r[23:0], rx_data};
      end else begin
        spa_nx = spa_r;
      end
      if (rx_eof) begin
        if (chk_idx_s == HDR_LAST) begin
          state_nx = P_CHECK;
          idx_nx   = chk_idx_s;
        end else begin
          // Frame ended inside the header: too short to be ARP
          state_nx = P_IDLE;
          idx_nx   = 6'd0;
          drop_nx  = sat_inc8(drop_r);
        end
      end else if (chk_idx_s == HDR_LAST) begin
        state_nx = P_TAIL;
        idx_nx   = chk_idx_s;
      end else begin
        state_nx = P_HDR;
        idx_nx   = chk_idx_s + 6'd1;
      end
    end else begin
      case (state_r)
        P_TAIL: begin
          if (rx_valid && rx_eof) begin
            state_nx = P_CHECK;
          end else begin
            state_nx = P_TAIL;
          end
        end
        P_CHECK: begin
          state_nx = P_IDLE;
          idx_nx   = 6'd0;
          // No queueing: a request arriving during a reply is dropped
          if (match_r && !start_r) begin
            start_nx = 1'b1;
            mac_nx   = sha_r;
            ip_nx    = spa_r;
          end else begin
            drop_nx  = sat_inc8(drop_r);
          end
        end
        default: state_nx = state_r;
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (areset) begin
      state_r <= P_IDLE;
      idx_r   <= 6'd0;
      match_r <= 1'b1;
      bcast_r <= 1'b1;
      mine_r  <= 1'b1;
      sha_r   <= 48'd0;
      spa_r   <= 32'd0;
      start_r <= 1'b0;
      mac_r   <= 48'd0;
      ip_r    <= 32'd0;
      drop_r  <= 8'd0;
    end else begin
      state_r <= state_nx;
      idx_r   <= idx_nx;
      match_r <= match_nx;
      bcast_r <= bcast_nx;
      mine_r  <= mine_nx;
      sha_r   <= sha_nx;
      spa_r   <= spa_nx;
      start_r <= start_nx;
      mac_r   <= mac_nx;
      ip_r    <= ip_nx;
      drop_r  <= drop_nx;
    end
  end

  assign reply_start = start_r;
  assign req_mac     = mac_r;
  assign req_ip      = ip_r;
  assign drop_cnt    = drop_r;

endmodule

// File: tb/tb_arp_rx_parser.sv
// Self-checking bench for arp_rx_parser: directed frame table, hand-written
// corner sequences and randomized frames checked against a frame-level model.
module tb_arp_rx_parser;

  localparam logic [47:0] MY_MAC = 48'h000A35010203;
  localparam logic [31:0] MY_IP  = 32'hC0A80164;
  localparam logic [47:0] BCAST  = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] SHA_A  = 48'h021122334455;
  localparam logic [47:0] SHA_B  = 48'h021122334466;
  localparam logic [47:0] SHA_C  = 48'h02AABBCCDDEE;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_sof = 1'b0;
  logic        rx_eof = 1'b0;
  logic        tx_done = 1'b0;
  logic        reply_start;
  logic [47:0] req_mac;
  logic [31:0] req_ip;
  logic [7:0]  drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  fb[$];
  bit          gaps_on = 1'b0;

  // Frame-level reference model state
  bit          m_start = 1'b0;
  logic [47:0] m_mac   = 48'd0;
  logic [31:0] m_ip    = 32'd0;
  int          m_drop  = 0;

  typedef struct {
    logic [47:0] dmac;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [31:0] tpa;
    logic [15:0] oper;
    int          len;
    int          corrupt;
    bit          txd;
    bit          e_start;
    logic [47:0] e_mac;
    logic [31:0] e_ip;
    logic [7:0]  e_drop;
  } vec_t;

  vec_t vt[13];

  always #5 clk = ~clk;

  arp_rx_parser #(
    .MY_MAC (MY_MAC),
    .MY_IP  (MY_IP)
  ) dut (
    .clk         (clk),
    .areset      (areset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_sof      (rx_sof),
    .rx_eof      (rx_eof),
    .tx_done     (tx_done),
    .reply_start (reply_start),
    .req_mac     (req_mac),
    .req_ip      (req_ip),
    .drop_cnt    (drop_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Build an Ethernet/ARP frame into fb, truncated or padded to len bytes
  function automatic void build(input logic [47:0] dmac, input logic [47:0] sha,
                                input logic [31:0] spa, input logic [31:0] tpa,
                                input logic [15:0] oper, input int len, input int corrupt);
    fb.delete();
    for (int i = 0; i < 6; i++) fb.push_back(dmac[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) fb.push_back(8'h5A);
    fb.push_back(8'h08); fb.push_back(8'h06);
    fb.push_back(8'h00); fb.push_back(8'h01);
    fb.push_back(8'h08); fb.push_back(8'h00);
    fb.push_back(8'h06); fb.push_back(8'h04);
    fb.push_back(oper[15:8]); fb.push_back(oper[7:0]);
    for (int i = 0; i < 6; i++) fb.push_back(sha[47-8*i -: 8]);
    for (int i = 0; i < 4; i++) fb.push_back(spa[31-8*i -: 8]);
    for (int i = 0; i < 6; i++) fb.push_back(8'h00);
    for (int i = 0; i < 4; i++) fb.push_back(tpa[31-8*i -: 8]);
    while (fb.size() < len) fb.push_back(8'($urandom_range(0, 255)));
    while (fb.size() > len) void'(fb.pop_back());
    if (corrupt >= 0 && corrupt < fb.size()) fb[corrupt] = fb[corrupt] ^ 8'h01;
  endfunction

  // Judge the frame in fb as a whole and update the expected outputs
  function automatic void model_frame();
    logic [47:0] dm, sha;
    logic [31:0] spa, tpa;
    bit ok;
    if (fb.size() < 42) begin
      m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      return;
    end
    dm = 48'd0; sha = 48'd0; spa = 32'd0; tpa = 32'd0;
    for (int i = 0; i < 6; i++) dm  = {dm[39:0], fb[i]};
    for (int i = 0; i < 6; i++) sha = {sha[39:0], fb[22+i]};
    for (int i = 0; i < 4; i++) spa = {spa[23:0], fb[28+i]};
    for (int i = 0; i < 4; i++) tpa = {tpa[23:0], fb[38+i]};
    ok = (dm == BCAST || dm == MY_MAC) &&
         ({fb[12], fb[13]} == 16'h0806) && ({fb[14], fb[15]} == 16'h0001) &&
         ({fb[16], fb[17]} == 16'h0800) && (fb[18] == 8'h06) && (fb[19] == 8'h04) &&
         ({fb[20], fb[21]} == 16'h0001) && (tpa == MY_IP);
    if (ok && !m_start) begin
      m_start = 1'b1;
      m_mac   = sha;
      m_ip    = spa;
    end else begin
      m_drop = (m_drop < 255) ? m_drop + 1 : 255;
    end
  endfunction

  // Drive the first n bytes of fb, with optional idle gaps carrying junk
  task automatic send_bytes(input int n, input bit with_eof);
    for (int i = 0; i < n; i++) begin
      if (gaps_on && $urandom_range(0, 3) == 0) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom_range(0, 255));
        rx_sof   = 1'($urandom_range(0, 1));
        rx_eof   = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      rx_valid = 1'b1;
      rx_data  = fb[i];
      rx_sof   = (i == 0);
      rx_eof   = with_eof && (i == n - 1);
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    rx_sof   = 1'b0;
    rx_eof   = 1'b0;
  endtask

  // Send the whole frame, then check outputs one edge after the decision edge
  task automatic run_frame(input string tag);
    bit prev;
    prev = m_start;
    send_bytes(fb.size(), 1'b1);
    check({tag, "_start_latency"}, 64'(reply_start), 64'(prev));
    model_frame();
    @(posedge clk);
    #1;
    check({tag, "_start"}, 64'(reply_start), 64'(m_start));
    check({tag, "_mac"},   64'(req_mac),     64'(m_mac));
    check({tag, "_ip"},    64'(req_ip),      64'(m_ip));
    check({tag, "_drop"},  64'(drop_cnt),    64'(m_drop));
  endtask

  task automatic pulse_tx_done(input string tag);
    tx_done = 1'b1;
    @(posedge clk);
    #1;
    tx_done = 1'b0;
    m_start = 1'b0;
    check({tag, "_release"}, 64'(reply_start), 64'(0));
  endtask

  task automatic do_reset(input string tag);
    rx_valid = 1'b0;
    rx_sof   = 1'b0;
    rx_eof   = 1'b0;
    areset   = 1'b1;
    @(posedge clk);
    #1;
    areset  = 1'b0;
    m_start = 1'b0;
    m_mac   = 48'd0;
    m_ip    = 32'd0;
    m_drop  = 0;
    check({tag, "_rst_start"}, 64'(reply_start), 64'(0));
    check({tag, "_rst_mac"},   64'(req_mac),     64'(0));
    check({tag, "_rst_ip"},    64'(req_ip),      64'(0));
    check({tag, "_rst_drop"},  64'(drop_cnt),    64'(0));
  endtask

  initial begin
    // Directed table: dmac, sha, spa, tpa, oper, len, corrupt, txd | expected
    vt[0]  = '{BCAST, SHA_A, 32'hC0A80105, MY_IP, 16'h0001, 60, -1, 1'b1, 1'b1, SHA_A, 32'hC0A80105, 8'd0};
    vt[1]  = '{BCAST, SHA_A, 32'hC0A80105, 32'hC0A80165, 16'h0001, 60, -1, 1'b0, 1'b0, SHA_A, 32'hC0A80105, 8'd1};
    vt[2]  = '{BCAST, SHA_A, 32'hC0A80105, MY_IP, 16'h0002, 60, -1, 1'b0, 1'b0, SHA_A, 32'hC0A80105, 8'd2};
    vt[3]  = '{BCAST, SHA_A, 32'hC0A80105, MY_IP, 16'h0001, 31, -1, 1'b0, 1'b0, SHA_A, 32'hC0A80105, 8'd3};
    vt[4]  = '{MY_MAC, SHA_A, 32'hC0A80107, MY_IP, 16'h0001, 42, -1, 1'b0, 1'b1, SHA_A, 32'hC0A80107, 8'd3};
    vt[5]  = '{BCAST, SHA_B, 32'hC0A80108, MY_IP, 16'h0001, 60, -1, 1'b1, 1'b1, SHA_A, 32'hC0A80107, 8'd4};
    vt[6]  = '{48'h000A35010204, SHA_B, 32'hC0A80108, MY_IP, 16'h0001, 60, -1, 1'b0, 1'b0, SHA_A, 32'hC0A80107, 8'd5};
    vt[7]  = '{BCAST, SHA_B, 32'hC0A80108, MY_IP, 16'h0001, 60, 13, 1'b0, 1'b0, SHA_A, 32'hC0A80107, 8'd6};
    vt[8]  = '{BCAST, SHA_B, 32'hC0A80108, MY_IP, 16'h0001, 60, 19, 1'b0, 1'b0, SHA_A, 32'hC0A80107, 8'd7};
    vt[9]  = '{BCAST, SHA_C, 32'hC0A80109, MY_IP, 16'h0001, 50, 7, 1'b1, 1'b1, SHA_C, 32'hC0A80109, 8'd7};
    vt[10] = '{48'hFF0A35010203, SHA_B, 32'hC0A80108, MY_IP, 16'h0001, 60, -1, 1'b0, 1'b0, SHA_C, 32'hC0A80109, 8'd8};
    vt[11] = '{48'hFFFFFFFFFFFE, SHA_B, 32'hC0A80108, MY_IP, 16'h0001, 60, -1, 1'b0, 1'b0, SHA_C, 32'hC0A80109, 8'd9};
    vt[12] = '{BCAST, SHA_B, 32'hC0A80108, MY_IP, 16'h0001, 60, 40, 1'b0, 1'b0, SHA_C, 32'hC0A80109, 8'd10};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    areset = 1'b0;
    check("reset_start", 64'(reply_start), 64'(0));
    check("reset_mac",   64'(req_mac),     64'(0));
    check("reset_ip",    64'(req_ip),      64'(0));
    check("reset_drop",  64'(drop_cnt),    64'(0));

    // Table-driven frames with random valid gaps
    gaps_on = 1'b1;
    for (int r = 0; r < 13; r++) begin
      build(vt[r].dmac, vt[r].sha, vt[r].spa, vt[r].tpa, vt[r].oper, vt[r].len, vt[r].corrupt);
      run_frame($sformatf("row%0d", r));
      check($sformatf("row%0d_tbl_start", r), 64'(reply_start), 64'(vt[r].e_start));
      check($sformatf("row%0d_tbl_mac", r),   64'(req_mac),     64'(vt[r].e_mac));
      check($sformatf("row%0d_tbl_ip", r),    64'(req_ip),      64'(vt[r].e_ip));
      check($sformatf("row%0d_tbl_drop", r),  64'(drop_cnt),    64'(vt[r].e_drop));
      if (vt[r].txd) pulse_tx_done($sformatf("row%0d", r));
    end

    // sof reasserted at byte 15 of a frame, then a full valid frame
    build(BCAST, SHA_B, 32'hC0A80110, MY_IP, 16'h0001, 60, -1);
    send_bytes(15, 1'b0);
    build(BCAST, 48'h023344556677, 32'hC0A80111, MY_IP, 16'h0001, 46, -1);
    run_frame("sof_restart");
    check("sof_restart_mac", 64'(req_mac), 64'(48'h023344556677));
    pulse_tx_done("sof_restart");

    // sof reasserted while discarding padding
    build(BCAST, SHA_B, 32'hC0A80112, MY_IP, 16'h0001, 60, -1);
    send_bytes(50, 1'b0);
    build(MY_MAC, 48'h024455667788, 32'hC0A80113, MY_IP, 16'h0001, 44, -1);
    run_frame("tail_restart");
    pulse_tx_done("tail_restart");

    // areset in the middle of a valid frame
    build(BCAST, SHA_B, 32'hC0A80114, MY_IP, 16'h0001, 60, -1);
    send_bytes(25, 1'b0);
    do_reset("midframe");
    build(BCAST, SHA_A, 32'hC0A80115, MY_IP, 16'h0001, 60, -1);
    run_frame("after_rst1");

    // areset while reply_start is high
    do_reset("midreply");
    build(BCAST, SHA_C, 32'hC0A80116, MY_IP, 16'h0001, 42, -1);
    run_frame("after_rst2");
    pulse_tx_done("after_rst2");

    // Randomized frames against the model
    for (int k = 0; k < 80; k++) begin
      logic [47:0] dm;
      logic [47:0] sha;
      logic [31:0] tpa;
      logic [15:0] op;
      int ln, cr;
      case ($urandom_range(0, 3))
        0:       dm = BCAST;
        1:       dm = MY_MAC;
        2:       dm = {16'($urandom), 32'($urandom)};
        default: dm = MY_MAC ^ (48'd1 << $urandom_range(0, 47));
      endcase
      sha = {16'($urandom), 32'($urandom)};
      tpa = ($urandom_range(0, 4) == 0) ? 32'($urandom) : MY_IP;
      op  = ($urandom_range(0, 4) == 0) ? 16'h0002 : 16'h0001;
      ln  = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, 41)) : int'($urandom_range(42, 64));
      cr  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 41)) : -1;
      build(dm, sha, 32'($urandom), tpa, op, ln, cr);
      run_frame($sformatf("rnd%0d", k));
      if ($urandom_range(0, 1) == 1) pulse_tx_done($sformatf("rnd%0d", k));
    end

    // 300 rejected frames drive the counter into saturation
    gaps_on = 1'b0;
    for (int k = 0; k < 300; k++) begin
      build(BCAST, SHA_B, 32'hC0A80120, MY_IP, 16'h0001, int'($urandom_range(1, 8)), -1);
      send_bytes(fb.size(), 1'b1);
      model_frame();
    end
    @(posedge clk);
    #1;
    check("drop_saturate", 64'(drop_cnt), 64'(8'hFF));
    check("drop_model",    64'(drop_cnt), 64'(m_drop));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
